// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL power-up / lock sequencer.
// Holds the sequencer state encoding (also reused by the Wishbone status
// register) and the helper that sizes the shared down-counter.
package pll_rst_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Width of the shared counter: clog2 of the largest interval, plus one.
  function automatic int unsigned seq_cnt_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return unsigned'($clog2(m)) + 32'd1;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync2_ff.sv
// Generic 2-flop synchronizer for asynchronous level inputs.
// Ports: clk      - destination clock
//        rst_n    - asynchronous active-low reset (flops clear to 0)
//        d        - asynchronous input
//        q        - synchronized output, two clk edges behind d
module sync2_ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL power-up and lock sequencer, running on the crystal clock.
// Holds the PLL powered down, waits for a stable synchronized LOCK, then
// releases the system reset. Retries on lock timeout, re-sequences on loss
// of lock, and parks in FAIL after MAX_RETRIES timeouts.
// Ports: sys_clk_pad_i - crystal clock (only clock)
//        rst_n_pad_i   - asynchronous active-low reset
//        pll_lock_i    - raw PLL LOCK, asynchronous
//        restart_i     - one-cycle pulse: full re-sequence, clears sticky flags
//        pll_pwrdn_n_o - PLL POWERDOWN pin, 0 = powered down
//        sys_rst_o     - active-high reset for PLL-clocked logic
//        locked_o      - high only in RUN
//        lock_lost_o   - sticky, set on lock loss in RUN
//        fail_o        - high in FAIL
//        retry_cnt_o   - timeouts in the current sequence
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned PWRDN_CYCLES        = 64,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                               sys_clk_pad_i,
  input  logic                               rst_n_pad_i,
  input  logic                               pll_lock_i,
  input  logic                               restart_i,
  output logic                               pll_pwrdn_n_o,
  output logic                               sys_rst_o,
  output logic                               locked_o,
  output logic                               lock_lost_o,
  output logic                               fail_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o
);

  localparam int unsigned CW = seq_cnt_width(PWRDN_CYCLES, LOCK_STABLE_CYCLES,
                                             LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] CNT_PWRDN   = CW'(PWRDN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_STABLE  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);

  logic          lock_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_d;
  logic          lock_lost_d;

  // LOCK synchronizer
  sync2_ff #(.W(1)) u_lock_sync (
    .clk   (sys_clk_pad_i),
    .rst_n (rst_n_pad_i),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  // Next-state logic. cnt counts down to 0; each timed state is left on the
  // edge that observes 0, so a load of N-1 gives exactly N cycles in state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_cnt_o;
    lock_lost_d = lock_lost_o;

    if (restart_i) begin
      state_d     = ST_PWRDN;
      cnt_d       = CNT_PWRDN;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_PWRDN: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_TIMEOUT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_STABLE;
          end else if (cnt_q == '0) begin
            // Increment cannot exceed MAX_RETRIES: the last one goes to FAIL.
            retry_d = retry_cnt_o + RW'(1);
            cnt_d   = CNT_PWRDN;
            state_d = (retry_cnt_o == RETRY_LAST) ? ST_FAIL : ST_PWRDN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_TIMEOUT;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d     = ST_PWRDN;
            cnt_d       = CNT_PWRDN;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PWRDN;
          cnt_d   = CNT_PWRDN;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are decoded from next-state.
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state_q       <= ST_PWRDN;
      cnt_q         <= CNT_PWRDN;
      retry_cnt_o   <= '0;
      lock_lost_o   <= 1'b0;
      pll_pwrdn_n_o <= 1'b0;
      sys_rst_o     <= 1'b1;
      locked_o      <= 1'b0;
      fail_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_cnt_o   <= retry_d;
      lock_lost_o   <= lock_lost_d;
      pll_pwrdn_n_o <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_RUN);
      sys_rst_o     <= (state_d != ST_RUN);
      locked_o      <= (state_d == ST_RUN);
      fail_o        <= (state_d == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Testbench for pll_rst_seq with small intervals (4/8/32, 2 retries).
// Stimulus rows {lock, restart, cycles, expected outputs} are applied edge by
// edge; expected values are queued when driven and compared #1 after the edge.
module tb_pll_rst_seq;

  localparam int unsigned PWRDN_C   = 4;
  localparam int unsigned STABLE_C  = 8;
  localparam int unsigned TIMEOUT_C = 32;
  localparam int unsigned RETRIES   = 2;

  // Expected output vector: {pwrdn_n, sys_rst, locked, lock_lost, fail, retry[1:0]}
  localparam logic [6:0] O_PD     = 7'b0100000;
  localparam logic [6:0] O_WT     = 7'b1100000;
  localparam logic [6:0] O_RUN    = 7'b1010000;
  localparam logic [6:0] O_PD_LL  = 7'b0101000;
  localparam logic [6:0] O_WT_LL  = 7'b1101000;
  localparam logic [6:0] O_RUN_LL = 7'b1011000;
  localparam logic [6:0] O_PD_R1  = 7'b0100001;
  localparam logic [6:0] O_WT_R1  = 7'b1100001;
  localparam logic [6:0] O_FAIL   = 7'b0100110;

  logic       sys_clk;
  logic       rst_n;
  logic       lock;
  logic       restart;
  logic       pll_pwrdn_n;
  logic       sys_rst;
  logic       locked;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [6:0] obs;

  typedef struct {
    logic       lock;
    logic       restart;
    int         n;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         checks;
  int         errors;
  int         edge_n;

  pll_rst_seq #(
    .PWRDN_CYCLES        (PWRDN_C),
    .LOCK_STABLE_CYCLES  (STABLE_C),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT_C),
    .MAX_RETRIES         (RETRIES)
  ) dut (
    .sys_clk_pad_i (sys_clk),
    .rst_n_pad_i   (rst_n),
    .pll_lock_i    (lock),
    .restart_i     (restart),
    .pll_pwrdn_n_o (pll_pwrdn_n),
    .sys_rst_o     (sys_rst),
    .locked_o      (locked),
    .lock_lost_o   (lock_lost),
    .fail_o        (fail),
    .retry_cnt_o   (retry_cnt)
  );

  assign obs = {pll_pwrdn_n, sys_rst, locked, lock_lost, fail, retry_cnt};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [6:0] e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s edge %0d got %b exp %b", tag, edge_n, obs, e);
    end
  endtask

  task automatic add(input logic lk, input logic rs, input int n,
                     input logic [6:0] e, input string tag);
    vec_t v;
    v.lock = lk; v.restart = rs; v.n = n; v.exp = e; v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic lk, input logic rs, input logic [6:0] e,
                     input string tag);
    lock    = lk;
    restart = rs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge sys_clk);
    edge_n++;
    #1;
    check(tag_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc(tbl[i].lock, tbl[i].restart, tbl[i].exp, tbl[i].tag);
      end
    end
    restart = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    edge_n  = 0;
    rst_n   = 1'b0;
    lock    = 1'b0;
    restart = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset", O_PD);
    rst_n = 1'b1;

    // nominal power-up and lock (edges counted from reset release)
    add(0, 0,  3, O_PD,     "nom_pwrdn");
    add(0, 0, 11, O_WT,     "nom_wait");
    add(1, 0, 10, O_WT,     "nom_qual");
    add(1, 0,  5, O_RUN,    "nom_run");
    // loss of lock in RUN, then clean re-lock
    add(0, 0,  2, O_RUN,    "loss_sync");
    add(0, 0,  4, O_PD_LL,  "loss_pwrdn");
    add(0, 0,  3, O_WT_LL,  "loss_wait");
    add(1, 0, 10, O_WT_LL,  "loss_qual");
    add(1, 0,  3, O_RUN_LL, "loss_run");
    // restart coinciding with lock drop reaching the FSM in RUN
    add(0, 0,  2, O_RUN_LL, "rst_drop_sync");
    add(0, 1,  1, O_PD,     "rst_drop_restart");
    add(0, 0,  3, O_PD,     "rst_drop_pwrdn");
    // glitch in STABLE restarts qualification
    add(0, 0,  2, O_WT,     "gl_wait");
    add(1, 0,  7, O_WT,     "gl_qual");
    add(0, 0,  2, O_WT,     "gl_drop");
    add(1, 0, 10, O_WT,     "gl_requal");
    add(1, 0,  2, O_RUN,    "gl_run");
    // timeout, retry, fail
    add(0, 1,  1, O_PD,     "to_restart");
    add(0, 0,  3, O_PD,     "to_pwrdn0");
    add(0, 0, 32, O_WT,     "to_wait0");
    add(0, 0,  4, O_PD_R1,  "to_pwrdn1");
    add(0, 0, 32, O_WT_R1,  "to_wait1");
    add(0, 0, 20, O_FAIL,   "to_fail");
    // restart out of FAIL, then restart colliding with a timeout
    add(0, 1,  1, O_PD,     "fail_restart");
    add(0, 0,  3, O_PD,     "fail_pwrdn");
    add(0, 0, 32, O_WT,     "col_wait");
    add(0, 1,  1, O_PD,     "col_restart");
    // walk into STABLE for the async reset case
    add(0, 0,  3, O_PD,     "pre_pwrdn");
    add(1, 0,  5, O_WT,     "pre_stable");
    run_tbl();

    // async reset between edges while in STABLE
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", O_PD);
    @(posedge sys_clk);
    #1;
    check("rst_hold", O_PD);
    rst_n  = 1'b1;
    edge_n = 0;

    // restart from reset with lock already high
    tbl.delete();
    add(1, 0, 3, O_PD,  "post_pwrdn");
    add(1, 0, 9, O_WT,  "post_qual");
    add(1, 0, 2, O_RUN, "post_run");
    run_tbl();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
